// File: rtl/ram_sp_bus_master.sv
// -----------------------------------------------------------------------------
// ram_sp_bus_master
// Initiator for a single-port, synchronous-read, single-bus RAM. Accepts one
// read or write request at a time from a core-side valid/ready port, sequences
// the RAM pins, captures read data and hands it back on a valid/ready response
// port. Write completion is reported with a one-cycle wr_done pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write/addr/wdata     request payload (1 = write, 0 = read)
//   resp_valid/resp_ready    read-response handshake
//   resp_rdata               captured read word, held until the next sample
//   wr_done                  one-cycle pulse after the RAM write edge
//   mem_cs/we/oe/address     RAM control and address pins
//   mem_data                 shared bus, driven only while writing, else Z
//
// All pin and handshake outputs are flops loaded from the next-state value,
// so they depend on the state register only and never combinationally on
// the req_* inputs.
// -----------------------------------------------------------------------------
module ram_sp_bus_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  wr_done,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // Counter reload: RD_WAIT is left when the count reaches zero, so a
    // load of RD_LAT-1 puts the sample edge RD_LAT edges after RD_ADDR.
    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [3:0]            cnt_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [ADDR_WIDTH-1:0] address_r;
    logic                  cs_r;
    logic                  we_r;
    logic                  oe_r;
    logic                  drive_r;
    logic                  resp_valid_r;
    logic                  wr_done_r;
    logic                  req_ready_r;
    logic                  accept_s;
    logic                  sample_s;

    // Handshake qualifiers decoded from the current state.
    always_comb begin
        accept_s = 1'b0;
        sample_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = req_valid;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == ST_RD_WAIT) && (cnt_r == 4'd0)) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end
    end

    // Next-state decode of the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = req_write ? ST_WRITE : ST_RD_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE:   state_nxt_s = ST_IDLE;
            ST_RD_ADDR: state_nxt_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            ST_RESP: begin
                // resp_valid is always high in RESP, so resp_ready alone
                // completes the handshake.
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State, payload latches, latency counter and registered pin decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            wdata_r      <= {DATA_WIDTH{1'b0}};
            rdata_r      <= {DATA_WIDTH{1'b0}};
            address_r    <= {ADDR_WIDTH{1'b0}};
            cs_r         <= 1'b0;
            we_r         <= 1'b0;
            oe_r         <= 1'b0;
            drive_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            wr_done_r    <= 1'b0;
            req_ready_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;

            // The address register doubles as the latched request address;
            // it simply holds while the RAM is deselected.
            if (accept_s) begin
                address_r <= req_addr;
                wdata_r   <= req_wdata;
            end

            if (state_r == ST_RD_ADDR) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_RD_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end

            if (sample_s) begin
                rdata_r <= mem_data;
            end

            cs_r         <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_RD_ADDR) ||
                            (state_nxt_s == ST_RD_WAIT);
            we_r         <= (state_nxt_s == ST_WRITE);
            oe_r         <= (state_nxt_s == ST_RD_ADDR) || (state_nxt_s == ST_RD_WAIT);
            drive_r      <= (state_nxt_s == ST_WRITE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            wr_done_r    <= (state_r == ST_WRITE);
            req_ready_r  <= (state_nxt_s == ST_IDLE);
        end
    end

    // Bus is driven only during WRITE, so a read (oe=1, we=0) never contends.
    assign mem_data    = drive_r ? wdata_r : {DATA_WIDTH{1'bz}};
    assign mem_cs      = cs_r;
    assign mem_we      = we_r;
    assign mem_oe      = oe_r;
    assign mem_address = address_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = rdata_r;
    assign wr_done     = wr_done_r;
    assign req_ready   = req_ready_r;

endmodule

// File: doc/ram_sp_bus_master.md
Name: ram_sp_bus_master

Overview:
- Initiator for the single-port, synchronous-read, single-bus RAM (ram_sp_sr_sw): it drives clk-domain cs/we/oe/address and the shared bidirectional data bus.
- Takes single-beat read/write requests from a core-side valid/ready port, sequences the RAM pins, captures read data and returns it on a valid/ready response port.
- Sits between the CPU load/store unit and data memory; one outstanding transaction at a time.

Parameters:
DATA_WIDTH, 64, width of RAM word and data bus
ADDR_WIDTH, 12, RAM address width
RD_LAT, 1, cycles from read address presentation to the data-sample edge; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  block can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  read data available
resp_ready  in  1  consumer takes read data
resp_rdata  out  DATA_WIDTH  captured read data
wr_done  out  1  one-cycle pulse: write committed to RAM
mem_cs  out  1  RAM chip select
mem_we  out  1  RAM write enable
mem_oe  out  1  RAM output enable
mem_address  out  ADDR_WIDTH  RAM address
mem_data  inout  DATA_WIDTH  shared data bus; driven only in WRITE, else high-Z

Behaviour:
- States: IDLE, WRITE, RD_ADDR, RD_WAIT, RESP. Pin outputs decode from the state register only, with no combinational path from the req_* inputs.
- Reset (rst=1 at an edge): state=IDLE; mem_cs=mem_we=mem_oe=0; mem_address=0; mem_data=Z; resp_valid=0; wr_done=0; resp_rdata=0. Reset aborts any transaction mid-flight. No write pulse is issued after reset, and a partially read word is discarded.
- IDLE: req_ready=1. When req_valid=1, the block latches addr, wdata and write on the same edge. Next state is WRITE if write=1, else RD_ADDR.
- Busy states (all except IDLE): req_ready=0. A req_valid asserted while busy is ignored and remains pending.
- WRITE (exactly 1 cycle):
  - Pins: cs=1, we=1, oe=0, address=latched addr, mem_data=latched wdata.
  - The RAM commits the word on the closing edge.
  - Next state is IDLE, with wr_done=1 for the following cycle.
- Write latency: request accepted at edge N; RAM write at edge N+1; wr_done high during cycle N+1..N+2; req_ready high again in cycle N+1..N+2.
- RD_ADDR (1 cycle): cs=1, we=0, oe=1, address=latched addr, mem_data=Z. Loads the latency counter with RD_LAT-1.
- RD_WAIT:
  - Pins are held as in RD_ADDR and the counter decrements each cycle.
  - When the counter is 0, resp_rdata <= mem_data on that edge and the next state is RESP.
  - With RD_LAT=1, RD_WAIT lasts exactly one cycle.
- Read latency: accepted at edge N; data sampled at edge N+1+RD_LAT; resp_valid high from cycle N+1+RD_LAT.
- RESP:
  - cs=we=oe=0, bus Z, resp_valid=1, resp_rdata stable.
  - On resp_valid && resp_ready, go to IDLE. resp_valid holds indefinitely under backpressure.
- Bus turnaround: the controller never drives mem_data while mem_oe=1 with we=0. Every state other than WRITE releases the bus, so write→read and read→write sequences cannot contend.
- resp_rdata holds its last value outside RESP. It changes only at the sample edge.
- mem_address holds its last value in IDLE/RESP (cs=0). This is don't-care to the RAM.

Test Plan:
- Reset, then write 0x000←0xA5: the single WRITE cycle shows cs=1, we=1, mem_data=0xA5; wr_done pulses one cycle later; RAM mem[0]=0xA5.
- Write 0x018←0x1234, then read 0x018: RAM mem[24]=0x1234; resp_valid rises 1+RD_LAT cycles after acceptance with resp_rdata=0x1234. Next, read 0x000 → 0xA5.
- Write 0x101←0x123456789AB immediately followed by a read of 0x101: no X on mem_data at any edge (no contention); resp_rdata=0x123456789AB.
- Read 0x018 with resp_ready held low for 3 cycles: resp_valid stays 1, resp_rdata=0x1234 stable, req_ready=0. Then resp_ready=1 for one cycle → IDLE, req_ready=1.
- Assert req_valid (write 0x019←0xDEAD) during RD_WAIT: the request is not accepted until IDLE. After acceptance mem[25]=0xDEAD and mem[24] is unchanged.
- Assert rst during RD_WAIT: the next cycle shows all pins 0, bus Z, resp_valid=0, no response ever issued. Rebuild with RD_LAT=3: resp_valid appears 4 cycles after acceptance.
